// File: rtl/led_scan_pkg.sv
// Shared definitions for the 16x16x2 LED scan-bus receiver: geometry, bus field
// positions, pixel-plane type, capture FSM states and a bit-reversal helper.
package led_scan_pkg;

  localparam int LED_ROWS = 16;
  localparam int LED_COLS = 16;

  // Field positions on the 36-bit scan bus
  localparam int ROW_MSB = 35;
  localparam int ROW_LSB = 32;
  localparam int GRN_MSB = 31;
  localparam int RED_MSB = 15;

  // [row][col] pixel plane; bit c of a row word is column c
  typedef logic [LED_ROWS-1:0][LED_COLS-1:0] pixel_plane_t;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } scan_state_t;

  // Column 0 sits in the MSB of each bus half, so a bus half maps to a row word
  // by mirroring the bit order.
  function automatic logic [15:0] bit_reverse16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_scan_decoder_if.sv
// Scan-bus side and published-frame side of the LED scan decoder.
// master: the bus driver / frame consumer; slave: the decoder itself.
interface led_scan_decoder_if;
  import led_scan_pkg::*;

  logic [35:0]  GPIO_1;
  logic         capture_en;
  pixel_plane_t RedPixels;
  pixel_plane_t GrnPixels;
  logic         frame_valid;
  logic         frame_done;
  logic         row_skip_err;
  logic [7:0]   err_count;

  modport master (
    output GPIO_1, capture_en,
    input  RedPixels, GrnPixels, frame_valid, frame_done, row_skip_err, err_count
  );

  modport slave (
    input  GPIO_1, capture_en,
    output RedPixels, GrnPixels, frame_valid, frame_done, row_skip_err, err_count
  );

endinterface

// File: rtl/led_scan_settle.sv
// Synchronizer plus stability filter for the scan bus. A bus word is accepted
// once it has been seen unchanged for SETTLE_CYCLES synced samples; exactly one
// accept is produced per stable dwell. Fields are presented in bus bit order.
module led_scan_settle
  import led_scan_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [35:0] i_bus,
  output logic        o_accept,
  output logic [3:0]  o_row,
  output logic [15:0] o_red,
  output logic [15:0] o_grn
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][35:0] r_sync;
  logic [35:0]                  r_prev;
  logic [CW-1:0]                r_cnt;
  logic                         r_flag;

  logic [35:0]   w_synced;
  logic          w_same;
  logic [CW-1:0] w_run;
  logic          w_flag;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_same   = (w_synced == r_prev);
  // w_run is (number of identical synced samples including this one) - 1
  assign w_run    = w_same ? ((r_cnt == SAT) ? SAT : r_cnt + CW'(1)) : '0;
  // A change of word re-arms the accept in the same cycle it is seen
  assign w_flag   = w_same & r_flag;
  assign o_accept = (w_run == SAT) & ~w_flag;

  assign o_row = w_synced[ROW_MSB:ROW_LSB];
  assign o_grn = w_synced[GRN_MSB:GRN_MSB-15];
  assign o_red = w_synced[RED_MSB:0];

  // Multi-flop synchronizer on every bus bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_bus};
    end
  end

  // Stability counter and one-shot accept flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 36'd0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      r_prev <= w_synced;
      r_cnt  <= w_run;
      r_flag <= w_flag | o_accept;
    end
  end

endmodule

// File: rtl/led_scan_decoder.sv
// Receive side of the 16x16x2 LED scan bus: filters the bus, checks row order,
// assembles a working frame and publishes it atomically to RedPixels/GrnPixels.
// Build option: define LED_SCAN_ERRCNT_EN to enable the saturating skip counter
// on err_count (otherwise err_count is tied to zero).
module led_scan_decoder
  import led_scan_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  led_scan_decoder_if.slave  bus
);

  logic        w_accept;
  logic [3:0]  w_row;
  logic [15:0] w_red;
  logic [15:0] w_grn;
  logic [15:0] w_red_row;
  logic [15:0] w_grn_row;
  logic [3:0]  w_prev_row;

  scan_state_t  r_state;
  logic [3:0]   r_expect;
  pixel_plane_t r_work_red;
  pixel_plane_t r_work_grn;
  logic         r_pub_pending;
  pixel_plane_t r_red_pix;
  pixel_plane_t r_grn_pix;
  logic         r_frame_valid;
  logic         r_frame_done;
  logic         r_skip_err;

  led_scan_settle #(
    .SYNC_STAGES   (SYNC_STAGES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_bus    (bus.GPIO_1),
    .o_accept (w_accept),
    .o_row    (w_row),
    .o_red    (w_red),
    .o_grn    (w_grn)
  );

  assign w_red_row  = bit_reverse16(w_red);
  assign w_grn_row  = bit_reverse16(w_grn);
  assign w_prev_row = r_expect - 4'd1;

  // Row-order FSM, working buffer and atomic frame publish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= HUNT;
      r_expect      <= 4'd0;
      r_work_red    <= '0;
      r_work_grn    <= '0;
      r_pub_pending <= 1'b0;
      r_red_pix     <= '0;
      r_grn_pix     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_skip_err    <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_skip_err    <= 1'b0;
      r_pub_pending <= 1'b0;
      if (!bus.capture_en) begin
        r_state <= HUNT;
      end else begin
        // Publish copies the buffer as it stood before any accept this cycle
        if (r_pub_pending) begin
          r_red_pix     <= r_work_red;
          r_grn_pix     <= r_work_grn;
          r_frame_done  <= 1'b1;
          r_frame_valid <= 1'b1;
        end
        if (w_accept) begin
          case (r_state)
            HUNT: begin
              if (w_row == 4'd0) begin
                r_work_red[0] <= w_red_row;
                r_work_grn[0] <= w_grn_row;
                r_expect      <= 4'd1;
                r_state       <= CAPTURE;
              end else begin
                r_state <= HUNT;
              end
            end
            CAPTURE: begin
              if (w_row == r_expect) begin
                r_work_red[w_row] <= w_red_row;
                r_work_grn[w_row] <= w_grn_row;
                if (w_row == 4'd15) begin
                  r_pub_pending <= 1'b1;
                  r_expect      <= 4'd0;
                end else begin
                  r_expect <= r_expect + 4'd1;
                end
              end else if (w_row == w_prev_row) begin
                // Data changed while the scan dwells on a row: refresh it
                r_work_red[w_row] <= w_red_row;
                r_work_grn[w_row] <= w_grn_row;
              end else begin
                r_skip_err <= 1'b1;
                r_work_red <= '0;
                r_work_grn <= '0;
                if (w_row == 4'd0) begin
                  r_work_red[0] <= w_red_row;
                  r_work_grn[0] <= w_grn_row;
                  r_expect      <= 4'd1;
                end else begin
                  r_state <= HUNT;
                end
              end
            end
            default: begin
              r_state <= HUNT;
            end
          endcase
        end
      end
    end
  end

  assign bus.RedPixels    = r_red_pix;
  assign bus.GrnPixels    = r_grn_pix;
  assign bus.frame_valid  = r_frame_valid;
  assign bus.frame_done   = r_frame_done;
  assign bus.row_skip_err = r_skip_err;

`ifdef LED_SCAN_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of out-of-order rows, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= 8'd0;
    end else if (r_skip_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_count = r_err_cnt;
`else
  assign bus.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_led_scan_decoder.sv
// Randomized scoreboard bench for led_scan_decoder. A frame-level reference
// model predicts published frames and row-skip pulses as stimulus is issued;
// a monitor compares them whenever the DUT signals frame_done / row_skip_err.
module tb_led_scan_decoder;
  import led_scan_pkg::*;

  localparam int SYNC   = 2;
  localparam int SETTLE = 4;

  typedef struct {
    pixel_plane_t red;
    pixel_plane_t grn;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  led_scan_decoder_if bus_if ();

  led_scan_decoder #(
    .SYNC_STAGES   (SYNC),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int     checks = 0;
  int     errors = 0;
  frame_t exp_frames[$];
  int     exp_errs[$];
  int     done_count = 0;
  int     last_done_cyc = -1;

  // reference model state
  logic [35:0]  m_cur;
  int           m_dwell;
  bit           m_acc;
  bit           m_hunt;
  bit           m_en;
  int           m_expect;
  int           m_err_total;
  pixel_plane_t m_wr, m_wg;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] mkword(input int r, input logic [15:0] red, input logic [15:0] grn);
    logic [3:0] r4;
    r4 = 4'(r);
    return {r4, grn, red};
  endfunction

  function automatic void model_reset();
    m_cur = 36'd0; m_dwell = 0; m_acc = 1'b0; m_hunt = 1'b1;
    m_expect = 0; m_err_total = 0; m_wr = '0; m_wg = '0;
  endfunction

  // Grn[r][c] = bus[31-c], Red[r][c] = bus[15-c]
  function automatic void model_write(input int r, input logic [15:0] red, input logic [15:0] grn);
    for (int c = 0; c < 16; c++) begin
      m_wr[r][c] = red[15-c];
      m_wg[r][c] = grn[15-c];
    end
  endfunction

  function automatic void model_accept(input logic [35:0] w);
    int r;
    frame_t f;
    r = int'(w[35:32]);
    if (!m_en) return;
    if (m_hunt) begin
      if (r == 0) begin
        model_write(0, w[15:0], w[31:16]);
        m_expect = 1; m_hunt = 1'b0;
      end
    end else if (r == m_expect) begin
      model_write(r, w[15:0], w[31:16]);
      if (r == 15) begin
        f.red = m_wr; f.grn = m_wg;
        exp_frames.push_back(f);
        m_expect = 0;
      end else begin
        m_expect = m_expect + 1;
      end
    end else if (r == (m_expect + 15) % 16) begin
      model_write(r, w[15:0], w[31:16]);
    end else begin
      exp_errs.push_back(1);
      m_err_total++;
      m_wr = '0; m_wg = '0;
      if (r == 0) begin
        model_write(0, w[15:0], w[31:16]);
        m_expect = 1;
      end else begin
        m_hunt = 1'b1;
      end
    end
  endfunction

  // Drive a bus word for 'hold' cycles; the model accepts a dwell once it has
  // lasted SETTLE cycles.
  task automatic send(input logic [35:0] w, input int hold);
    if (w != m_cur) begin
      m_cur = w; m_dwell = 0; m_acc = 1'b0;
    end
    bus_if.GPIO_1 = w;
    m_dwell += hold;
    if (!m_acc && m_dwell >= SETTLE) begin
      m_acc = 1'b1;
      model_accept(w);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input bit v);
    bus_if.capture_en = v;
    m_en = v;
    if (!v) m_hunt = 1'b1;
  endtask

  task automatic clean_frame(input bit glitch, output int t15);
    logic [15:0] one;
    one = 16'h0001;
    t15 = 0;
    for (int r = 0; r < 16; r++) begin
      if (glitch && r == 3) send(mkword(3, 16'hFFFF, 16'hFFFF), 2);
      if (r == 15) t15 = cyc;
      send(mkword(r, one << (15 - r), one << r), 8);
    end
  endtask

  // Scoreboard monitor
  pixel_plane_t last_r, last_g;
  always @(negedge clk) begin
    frame_t f;
    if (!reset) begin
      last_r = '0; last_g = '0;
    end else begin
      if (bus_if.frame_done) begin
        done_count++;
        last_done_cyc = cyc;
        if (exp_frames.size() == 0) begin
          check("unexpected_frame_done", 1'b1, 1'b0);
        end else begin
          f = exp_frames.pop_front();
          check("frame_red", bus_if.RedPixels, f.red);
          check("frame_grn", bus_if.GrnPixels, f.grn);
          check("frame_valid_at_done", bus_if.frame_valid, 1'b1);
        end
        last_r = bus_if.RedPixels;
        last_g = bus_if.GrnPixels;
      end else begin
        check("hold_red", bus_if.RedPixels, last_r);
        check("hold_grn", bus_if.GrnPixels, last_g);
      end
      if (bus_if.row_skip_err) begin
        if (exp_errs.size() == 0) check("unexpected_row_skip_err", 1'b1, 1'b0);
        else void'(exp_errs.pop_front());
      end
    end
  end

  function automatic logic [7:0] exp_errcnt();
`ifdef LED_SCAN_ERRCNT_EN
    return (m_err_total > 255) ? 8'd255 : 8'(m_err_total);
`else
    return 8'd0;
`endif
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t15, dc;
    pixel_plane_t ident, anti;
    logic [15:0] one;
    one = 16'h0001;
    for (int r = 0; r < 16; r++) begin
      ident[r] = one << r;
      anti[r]  = 16'h8000 >> r;
    end
    bus_if.GPIO_1 = 36'd0;
    bus_if.capture_en = 1'b1;
    m_en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_red", bus_if.RedPixels, '0);
    check("rst_valid", bus_if.frame_valid, 1'b0);
    reset = 1'b1;
    send(36'd0, 8);

    // identity / anti-diagonal frame and publish latency
    clean_frame(1'b0, t15);
    check("publish_latency", 32'(last_done_cyc - t15), 32'(SYNC + SETTLE + 1));
    check("ident_red", bus_if.RedPixels, ident);
    check("anti_grn", bus_if.GrnPixels, anti);
    check("valid_after_frame", bus_if.frame_valid, 1'b1);

    // short glitch between rows 2 and 3 is ignored
    dc = done_count;
    clean_frame(1'b1, t15);
    check("glitch_frame_count", 32'(done_count), 32'(dc + 1));
    check("glitch_red", bus_if.RedPixels, ident);

    // asynchronous reset mid-frame
    for (int r = 0; r < 8; r++) send(mkword(r, 16'($urandom), 16'($urandom)), 8);
    reset = 1'b0;
    #2;
    check("midrst_red", bus_if.RedPixels, '0);
    check("midrst_grn", bus_if.GrnPixels, '0);
    check("midrst_flags", {bus_if.frame_valid, bus_if.frame_done, bus_if.row_skip_err}, 3'b000);
    check("midrst_errcnt", bus_if.err_count, 8'd0);
    bus_if.GPIO_1 = 36'd0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    send(36'd0, 8);
    for (int r = 0; r < 8; r++) send(mkword(r, 16'($urandom), 16'($urandom)), 8);
    check("valid_low_partial", bus_if.frame_valid, 1'b0);
    for (int r = 8; r < 16; r++) send(mkword(r, 16'($urandom), 16'($urandom)), 8);
    send(m_cur, 4);
    check("valid_after_reset_frame", bus_if.frame_valid, 1'b1);

    // skipped row: 0,1,2,4
    dc = done_count;
    for (int r = 0; r < 3; r++) send(mkword(r, 16'h1234, 16'h4321), 8);
    send(mkword(4, 16'h1234, 16'h4321), 8);
    check("skip_no_frame", 32'(done_count), 32'(dc));
    clean_frame(1'b0, t15);
    check("skip_then_frame", 32'(done_count), 32'(dc + 1));
    check("errcnt_one", bus_if.err_count, exp_errcnt());

    // row 5 data changes while held
    for (int r = 0; r < 16; r++) begin
      if (r == 5) begin
        send(mkword(5, 16'h0001, 16'h0000), 8);
        send(mkword(5, 16'h8000, 16'h0000), 8);
      end else begin
        send(mkword(r, 16'h0000, 16'h0000), 8);
      end
    end
    send(m_cur, 2);
    check("row5_overwrite", bus_if.RedPixels[5], 16'h0001);

    // capture_en low during rows 6..9
    dc = done_count;
    for (int r = 0; r < 16; r++) begin
      if (r == 6) set_en(1'b0);
      if (r == 10) set_en(1'b1);
      send(mkword(r, 16'($urandom), 16'($urandom)), 8);
    end
    check("en_low_no_publish", 32'(done_count), 32'(dc));
    clean_frame(1'b0, t15);
    check("en_resume_publish", 32'(done_count), 32'(dc + 1));

    // 300 forced skips
    for (int i = 0; i < 300; i++) begin
      send(mkword(0, 16'($urandom), 16'($urandom)), SETTLE);
      send(mkword(2, 16'($urandom), 16'($urandom)), SETTLE);
    end
    send(m_cur, 10);
    check("errcnt_saturate", bus_if.err_count, exp_errcnt());

    // randomized frames with glitches, skips and refreshed rows
    for (int f = 0; f < 20; f++) begin
      for (int r = 0; r < 16; r++) begin
        if ($urandom_range(0, 9) == 0)
          send({4'($urandom), 32'($urandom)}, $urandom_range(1, SETTLE - 1));
        if ($urandom_range(0, 19) == 0) continue;
        send(mkword(r, 16'($urandom), 16'($urandom)), $urandom_range(SETTLE, 9));
        if ($urandom_range(0, 9) == 0)
          send(mkword(r, 16'($urandom), 16'($urandom)), $urandom_range(SETTLE, 9));
      end
    end
    send(m_cur, 20);
    check("frames_drained", 32'(exp_frames.size()), 32'd0);
    check("errs_drained", 32'(exp_errs.size()), 32'd0);
    check("errcnt_final", bus_if.err_count, exp_errcnt());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_scan_decoder.md
Name: led_scan_decoder

Overview:
Receive-side counterpart of the 16x16x2 LED scan bus. It samples the 36-bit row-scanned GPIO bus: row select on [35:32], green columns on [31:16], red columns on [15:0]. It filters transitions, checks that rows arrive in order, and rebuilds complete red/green frames into double-buffered pixel planes. It serves as a self-check monitor on the board, or as the input stage of a second board that mirrors the display.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on every bus bit (minimum 2)
SETTLE_CYCLES, 4, number of consecutive identical synced samples required before a bus word is accepted (minimum 1)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  asynchronous, active-low reset
GPIO_1  input  36  scan bus; [35:32] row, [31:16] green, [15:0] red
capture_en  input  1  enables writing captured rows
RedPixels  output  16x16  last complete red frame, [row][col]
GrnPixels  output  16x16  last complete green frame, [row][col]
frame_valid  output  1  high once at least one complete frame has been published
frame_done  output  1  one-cycle pulse when a new frame is published
row_skip_err  output  1  one-cycle pulse on an out-of-order row
err_count  output  8  saturating count of out-of-order rows (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous): clears the synchronizer flops, settle counter, accept flag and working buffer, and puts the FSM in HUNT. RedPixels, GrnPixels, frame_valid, frame_done, row_skip_err and err_count are all 0.
- Bit mapping for the row r on the bus: Grn[r][c] = GPIO_1[31-c] and Red[r][c] = GPIO_1[15-c], for c = 0..15.
- Synchronizer: all 36 bits pass through SYNC_STAGES flops.
- Settle filter:
  - If the synced word differs from the previous cycle's word, the counter goes to 0 and the accepted flag clears.
  - Otherwise the counter increments, saturating.
  - When the word has been stable SETTLE_CYCLES cycles and the accepted flag is clear, emit a one-cycle accept (row, red16, grn16) and set the flag. This gives exactly one accept per stable dwell.
- Accept latency: SYNC_STAGES+SETTLE_CYCLES clk cycles after a bus change.
- FSM HUNT:
  - An accept of row 0 writes working row 0, sets expect=1 and moves to CAPTURE.
  - Any other row is ignored, with no error.
- FSM CAPTURE:
  - accept row == expect: write the working row and increment expect.
  - accept row == expect-1: this is a data change during a held row, e.g. the scan is paused. Overwrite that row; no error.
  - Row 15 written: on the next cycle, copy the working buffer to RedPixels/GrnPixels, pulse frame_done, set frame_valid, wrap expect to 0 and stay in CAPTURE.
  - Any other row:
    - Pulse row_skip_err in the cycle after the accept, and discard the working buffer.
    - If the row is 0, restart at row 0 (write it, expect=1).
    - Otherwise go to HUNT.
- Published frame: the outputs change only at frame publish and are never partially updated.
- capture_en low: the filter keeps running, the FSM is forced to HUNT, no writes occur, outputs hold, and no errors are raised. After capture_en rises, capture resumes only at the next accepted row 0.
- Simultaneous events: a frame publish and a new accept can occur in the same cycle. The publish copies the pre-accept working buffer, and the accept writes working.
- Reset mid-frame: full clear as above. frame_valid drops to 0.

Optional Feature:
LED_SCAN_ERRCNT_EN
- Defined: err_count increments on every row_skip_err pulse, saturating at 255, and is cleared only by reset.
- Undefined: the err_count port still exists and is tied to 8'd0, and the counter logic is absent.

Decomposition:
- Package led_scan_pkg:
  - LED_ROWS=16, LED_COLS=16
  - typedef pixel_plane_t = logic [15:0][15:0]
  - bus field constants ROW_MSB=35, ROW_LSB=32, GRN_MSB=31, RED_MSB=15
  - FSM enum {HUNT, CAPTURE}
- Sub-module led_scan_settle: synchronizer plus stability filter. It outputs accept, row[3:0], red[15:0] and grn[15:0] in bus order. The top level handles bit reversal, the FSM and the buffers.

Test Plan:
1. Reset low mid-frame -> all outputs 0 asynchronously; frame_valid=0 until the next full frame.
2. Rows 0..15, each held 8 cycles, red = (r==c), green = (c==15-r) -> exactly SYNC_STAGES+SETTLE_CYCLES+1 cycles after the row-15 bus change: RedPixels is the identity, GrnPixels the anti-diagonal, frame_done pulses 1 cycle, frame_valid=1.
3. Row 3 glitch held 2 cycles (< SETTLE_CYCLES=4) between rows 2 and 3 -> ignored; no row_skip_err; frame matches the clean frame.
4. Sequence 0,1,2,4 -> row_skip_err pulses once; no frame_done; outputs keep the previous frame; the next clean 0..15 frame publishes normally; err_count=1 with LED_SCAN_ERRCNT_EN defined (0 without).
5. Row 5 held while red[5] changes 16'h0001 -> 16'h8000 -> a second accept overwrites row 5 with no error; the published frame shows RedPixels[5] = the final value, bit-reversed per the mapping.
6. capture_en low during rows 6..9, then high at row 10 -> no publish until a complete 0..15 pass after re-enable; with the macro, 300 forced skips -> err_count=255.
